keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 155 +++++++++++++++
 tb/tb_keypad_scanner.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives col one-hot-low, debounces row, emits value + key_flag.
// Ports: clk, rst (sync active-low), row[3:0] in, col[3:0]/value[3:0]/key_flag/key_down out.
module keypad_scanner #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] value,
  output logic       key_flag,
  output logic       key_down
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    SCAN,
    CONFIRM,
    HELD,
    RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cidx_q, cidx_d;
  logic [1:0]    kr_q, kr_d;
  logic [3:0]    value_q, value_d;
  logic          flag_q, flag_d;
  logic          down_q, down_d;
  logic [3:0]    r1_q;
  logic [3:0]    rs_q;

  logic       tick;
  logic       hit;
  logic [1:0] kr_new;

  always_comb begin
    if (!rs_q[0])      kr_new = 2'd0;
    else if (!rs_q[1]) kr_new = 2'd1;
    else if (!rs_q[2]) kr_new = 2'd2;
    else               kr_new = 2'd3;
  end

  always_comb begin
    tick    = (div_q == DIV_LAST);
    hit     = ~rs_q[kr_q];
    div_d   = tick ? '0 : div_q + DW'(1);
    state_d = state_q;
    cnt_d   = cnt_q;
    cidx_d  = cidx_q;
    kr_d    = kr_q;
    value_d = value_q;
    flag_d  = 1'b0;
    down_d  = down_q;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (rs_q == 4'hF) begin
            cidx_d = cidx_q + 2'd1;
          end else begin
            kr_d = kr_new;
            if (DEBOUNCE_CNT == 1) begin
              value_d = {kr_new, cidx_q};
              flag_d  = 1'b1;
              down_d  = 1'b1;
              state_d = HELD;
            end else begin
              cnt_d   = CW'(1);
              state_d = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (hit) begin
            if (cnt_q == CNT_LAST) begin
              value_d = {kr_q, cidx_q};
              flag_d  = 1'b1;
              down_d  = 1'b1;
              state_d = HELD;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            state_d = SCAN;
            cidx_d  = cidx_q + 2'd1;
          end
        end
        HELD: begin
          if (!hit) begin
            if (DEBOUNCE_CNT == 1) begin
              down_d  = 1'b0;
              state_d = SCAN;
              cidx_d  = cidx_q + 2'd1;
            end else begin
              cnt_d   = CW'(1);
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (!hit) begin
            if (cnt_q == CNT_LAST) begin
              down_d  = 1'b0;
              state_d = SCAN;
              cidx_d  = cidx_q + 2'd1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SCAN;
      div_q   <= '0;
      cnt_q   <= '0;
      cidx_q  <= 2'd0;
      kr_q    <= 2'd0;
      value_q <= 4'd0;
      flag_q  <= 1'b0;
      down_q  <= 1'b0;
      r1_q    <= 4'hF;
      rs_q    <= 4'hF;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      cidx_q  <= cidx_d;
      kr_q    <= kr_d;
      value_q <= value_d;
      flag_q  <= flag_d;
      down_q  <= down_d;
      r1_q    <= row;
      rs_q    <= r1_q;
    end
  end

  assign col      = ~(4'b0001 << cidx_q);
  assign value    = value_q;
  assign key_flag = flag_q;
  assign key_down = down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, expected codes queued at press time,
// a monitor pops one per key_flag strobe.
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] value;
  logic       key_flag;
  logic       key_down;

  logic [15:0] keys;
  int          errs;
  int          checks;
  int          exp_q[$];
  logic        prev_flag;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .row(row),
    .col(col),
    .value(value),
    .key_flag(key_flag),
    .key_down(key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_down(input logic lvl, input int budget);
    int n;
    n = 0;
    while (key_down !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("key_down_wait", int'(key_down), int'(lvl));
  endtask

  task automatic wait_col(input logic [3:0] c, input int budget);
    int n;
    n = 0;
    while (col !== c && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("col_wait", int'(col), int'(c));
  endtask

  // Monitor: every strobe must match the oldest queued code.
  always @(negedge clk) begin
    if (rst) begin
      if (key_flag) begin
        chk("flag_not_back_to_back", int'(prev_flag), 0);
        chk("flag_with_down", int'(key_down), 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          chk("strobe_value", int'(value), exp_q.pop_front());
        end
      end
    end
    prev_flag <= key_flag;
  end

  initial begin
    logic [3:0] ecol;
    int k, r2, e;
    errs = 0;
    checks = 0;
    prev_flag = 1'b0;
    keys = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_col", int'(col), 4'b1110);
    chk("rst_value", int'(value), 0);
    chk("rst_flag", int'(key_flag), 0);
    chk("rst_down", int'(key_down), 0);
    rst = 1'b1;

    // Idle scan: column advances every 4 clocks.
    for (int n = 0; n < 20; n++) begin
      ecol = ~(4'b0001 << ((n / 4) % 4));
      chk("idle_col", int'(col), int'(ecol));
      @(negedge clk);
    end

    // Press row2/col1 then release.
    keys[9] = 1'b1;
    exp_q.push_back(9);
    wait_down(1'b1, 100);
    chk("held_col", int'(col), 4'b1101);
    repeat (20) @(negedge clk);
    chk("held_down", int'(key_down), 1);
    chk("held_col2", int'(col), 4'b1101);
    chk("held_value", int'(value), 9);
    keys = '0;
    wait_down(1'b0, 100);
    chk("resume_col", int'(col), 4'b1011);

    // Bounce on row0/col0: one-tick glitches never strobe.
    wait_col(4'b1110, 100);
    keys[0] = 1'b1;
    repeat (4) @(negedge clk);
    keys = '0;
    repeat (4) @(negedge clk);
    keys[0] = 1'b1;
    repeat (4) @(negedge clk);
    keys = '0;
    repeat (30) @(negedge clk);
    chk("bounce_down", int'(key_down), 0);
    chk("bounce_value", int'(value), 9);
    keys[0] = 1'b1;
    exp_q.push_back(0);
    wait_down(1'b1, 100);
    keys = '0;
    wait_down(1'b0, 100);

    // Two keys in column 3: lower row wins, other row re-detected later.
    keys[7] = 1'b1;
    keys[15] = 1'b1;
    exp_q.push_back(7);
    wait_down(1'b1, 100);
    repeat (10) @(negedge clk);
    keys[7] = 1'b0;
    exp_q.push_back(15);
    wait_down(1'b0, 100);
    wait_down(1'b1, 150);
    chk("redetect_col", int'(col), 4'b0111);
    keys = '0;
    wait_down(1'b0, 100);
    chk("redetect_value", int'(value), 15);

    // Reset while held: outputs clear, key re-strobed.
    keys[9] = 1'b1;
    exp_q.push_back(9);
    wait_down(1'b1, 100);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_value", int'(value), 0);
    chk("midrst_down", int'(key_down), 0);
    chk("midrst_flag", int'(key_flag), 0);
    chk("midrst_col", int'(col), 4'b1110);
    exp_q.push_back(9);
    wait_down(1'b1, 100);
    repeat (5) @(negedge clk);
    keys = '0;
    wait_down(1'b0, 100);

    // Random single keys and same-column pairs.
    for (int i = 0; i < 10; i++) begin
      k = $urandom_range(0, 15);
      keys[k] = 1'b1;
      e = k;
      if ($urandom_range(0, 1) == 1) begin
        r2 = $urandom_range(0, 3);
        keys[r2*4 + k%4] = 1'b1;
        if (r2 < k/4) e = r2*4 + k%4;
      end
      exp_q.push_back(e);
      wait_down(1'b1, 150);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      keys = '0;
      wait_down(1'b0, 100);
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
